// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter: owner tag, memory
// request struct and default widths.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_BM_W   = DMEM_DATA_W / 8;
  localparam int DMEM_CNT_W  = 16;

  // Requester slot indices inside the packed per-port arrays
  localparam int PORT_C    = 0;
  localparam int PORT_D    = 1;
  localparam int NUM_PORTS = 2;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic                   wren;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [DMEM_BM_W-1:0]   bmask;
  } mem_req_t;

  // Round-robin hand-off: whoever was just served yields to the other port
  function automatic owner_e next_prio(input logic [NUM_PORTS-1:0] gnt,
                                       input owner_e cur);
    owner_e nxt;
    nxt = cur;
    if (gnt[PORT_C])      nxt = OWN_D;
    else if (gnt[PORT_D]) nxt = OWN_C;
    return nxt;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker with a debug lock that masks port C.
// Purely combinational; the priority state lives in the parent.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 lock,
  input  owner_e               prio,
  output logic [NUM_PORTS-1:0] gnt
);

  logic c_elig;
  logic d_wins;

  assign c_elig = req[PORT_C] & ~lock;
  // D takes the slot when locked, when C is not eligible, or on its turn
  assign d_wins = req[PORT_D] & (lock | ~req[PORT_C] | (prio == OWN_D));

  always_comb begin
    gnt = '0;
    if (d_wins)      gnt[PORT_D] = 1'b1;
    else if (c_elig) gnt[PORT_C] = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous-read data memory between the core LSU
// (C) and the debug port (D); routes 1-cycle read data back to the owner.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int CNT_W  = DMEM_CNT_W
) (
  input  logic                i_clk,
  input  logic                i_reset,

  input  logic                i_c_req_vld,
  input  logic [ADDR_W-1:0]   i_c_req_addr,
  input  logic                i_c_req_wren,
  input  logic [DATA_W-1:0]   i_c_req_wdata,
  input  logic [DATA_W/8-1:0] i_c_req_bmask,
  output logic                o_c_req_rdy,
  output logic                o_c_rsp_vld,
  output logic [DATA_W-1:0]   o_c_rsp_rdata,

  input  logic                i_d_req_vld,
  input  logic [ADDR_W-1:0]   i_d_req_addr,
  input  logic                i_d_req_wren,
  input  logic [DATA_W-1:0]   i_d_req_wdata,
  input  logic [DATA_W/8-1:0] i_d_req_bmask,
  output logic                o_d_req_rdy,
  output logic                o_d_rsp_vld,
  output logic [DATA_W-1:0]   o_d_rsp_rdata,

  input  logic                i_d_lock,

  output logic                o_mem_en,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wren,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic [DATA_W-1:0]   i_mem_rdata,

  output logic [CNT_W-1:0]    o_c_stall_cnt
);

  logic     [NUM_PORTS-1:0]             req_vld;
  mem_req_t [NUM_PORTS-1:0]             req;
  logic     [NUM_PORTS-1:0]             gnt;
  mem_req_t                             mem_req;

  owner_e                               prio;
  logic                                 rsp_pend;
  owner_e                               rsp_own;
  logic                                 rsp_rd;
  logic     [NUM_PORTS-1:0]             rsp_vld;
  logic     [NUM_PORTS-1:0][DATA_W-1:0] rsp_rdata;

  logic     [CNT_W-1:0]                 stall_cnt;
  logic                                 c_stall;

  // ---- request gather ----
  assign req_vld[PORT_C] = i_c_req_vld;
  assign req_vld[PORT_D] = i_d_req_vld;

  always_comb begin
    req[PORT_C].addr  = i_c_req_addr;
    req[PORT_C].wren  = i_c_req_wren;
    req[PORT_C].wdata = i_c_req_wdata;
    req[PORT_C].bmask = i_c_req_bmask;
    req[PORT_D].addr  = i_d_req_addr;
    req[PORT_D].wren  = i_d_req_wren;
    req[PORT_D].wdata = i_d_req_wdata;
    req[PORT_D].bmask = i_d_req_bmask;
  end

  rr_arb2 u_rr (
    .req  (req_vld),
    .lock (i_d_lock),
    .prio (prio),
    .gnt  (gnt)
  );

  assign o_c_req_rdy = gnt[PORT_C];
  assign o_d_req_rdy = gnt[PORT_D];

  // ---- memory side: zeroed when idle so the macro sees a quiet bus ----
  always_comb begin
    mem_req = '0;
    if (gnt[PORT_D])      mem_req = req[PORT_D];
    else if (gnt[PORT_C]) mem_req = req[PORT_C];
  end

  assign o_mem_en    = |gnt;
  assign o_mem_addr  = mem_req.addr;
  assign o_mem_wren  = mem_req.wren;
  assign o_mem_wdata = mem_req.wdata;
  assign o_mem_bmask = mem_req.bmask;

  // ---- priority pointer ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) prio <= OWN_C;
    else         prio <= next_prio(gnt, prio);
  end

  // ---- response tracker: one access in flight, owner and read/write tag ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rsp_pend <= 1'b0;
      rsp_own  <= OWN_C;
      rsp_rd   <= 1'b0;
    end else begin
      rsp_pend <= |gnt;
      if (|gnt) begin
        rsp_own <= gnt[PORT_D] ? OWN_D : OWN_C;
        rsp_rd  <= ~mem_req.wren;
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    localparam owner_e OWN_P = (p == PORT_D) ? OWN_D : OWN_C;
    assign rsp_vld[p]   = rsp_pend & (rsp_own == OWN_P);
    assign rsp_rdata[p] = (rsp_vld[p] & rsp_rd) ? i_mem_rdata : '0;
  end

  assign o_c_rsp_vld   = rsp_vld[PORT_C];
  assign o_c_rsp_rdata = rsp_rdata[PORT_C];
  assign o_d_rsp_vld   = rsp_vld[PORT_D];
  assign o_d_rsp_rdata = rsp_rdata[PORT_D];

  // ---- core stall counter, sticks at all-ones ----
  assign c_stall = req_vld[PORT_C] & ~gnt[PORT_C];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                        stall_cnt <= '0;
    else if (c_stall && ~&stall_cnt)    stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign o_c_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grant checks inline, responses checked
// against a scoreboard queue by a negedge monitor.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = 16;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_c_req_vld, i_c_req_wren, o_c_req_rdy, o_c_rsp_vld;
  logic [AW-1:0] i_c_req_addr;
  logic [DW-1:0] i_c_req_wdata, o_c_rsp_rdata;
  logic [BW-1:0] i_c_req_bmask;
  logic          i_d_req_vld, i_d_req_wren, o_d_req_rdy, o_d_rsp_vld;
  logic [AW-1:0] i_d_req_addr;
  logic [DW-1:0] i_d_req_wdata, o_d_rsp_rdata;
  logic [BW-1:0] i_d_req_bmask;
  logic          i_d_lock;
  logic          o_mem_en, o_mem_wren;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [BW-1:0] o_mem_bmask;
  logic [DW-1:0] i_mem_rdata = '0;
  logic [CW-1:0] o_c_stall_cnt;

  typedef struct {
    logic          port;   // 0 = C, 1 = D
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   npass = 0;
  int   ntot  = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_c_req_vld(i_c_req_vld), .i_c_req_addr(i_c_req_addr), .i_c_req_wren(i_c_req_wren),
    .i_c_req_wdata(i_c_req_wdata), .i_c_req_bmask(i_c_req_bmask), .o_c_req_rdy(o_c_req_rdy),
    .o_c_rsp_vld(o_c_rsp_vld), .o_c_rsp_rdata(o_c_rsp_rdata),
    .i_d_req_vld(i_d_req_vld), .i_d_req_addr(i_d_req_addr), .i_d_req_wren(i_d_req_wren),
    .i_d_req_wdata(i_d_req_wdata), .i_d_req_bmask(i_d_req_bmask), .o_d_req_rdy(o_d_req_rdy),
    .o_d_rsp_vld(o_d_rsp_vld), .o_d_rsp_rdata(o_d_rsp_rdata),
    .i_d_lock(i_d_lock),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .o_mem_wren(o_mem_wren),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask), .i_mem_rdata(i_mem_rdata),
    .o_c_stall_cnt(o_c_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Memory macro model: 256 words, byte-masked writes, 1-cycle read latency
  logic [DW-1:0] mem [0:255];

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 4)  return 32'hDEAD_BEEF;   // byte 0x10
    if (i == 12) return 32'hCAFE_F00D;   // byte 0x30
    return 32'hA500_0000 | DW'(i);
  endfunction

  always @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (o_mem_en) begin
      if (o_mem_wren) begin
        for (int b = 0; b < BW; b++)
          if (o_mem_bmask[b]) mem[o_mem_addr[9:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end else begin
        i_mem_rdata <= mem[o_mem_addr[9:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic port, input logic [DW-1:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic chk_gnt(input string tag, input logic c, input logic d,
                         input logic [AW-1:0] addr, input logic wren);
    chk({tag, "_c_rdy"}, 64'(o_c_req_rdy), 64'(c));
    chk({tag, "_d_rdy"}, 64'(o_d_req_rdy), 64'(d));
    chk({tag, "_mem_en"}, 64'(o_mem_en), 64'(c | d));
    if (c | d) begin
      chk({tag, "_mem_addr"}, 64'(o_mem_addr), 64'(addr));
      chk({tag, "_mem_wren"}, 64'(o_mem_wren), 64'(wren));
    end
  endtask

  task automatic next_cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Response monitor: every presented response must match the queue head
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_c_rsp_vld || o_d_rsp_vld) begin
        if (q.size() == 0) begin
          chk("rsp_spurious", {62'b0, o_c_rsp_vld, o_d_rsp_vld}, 64'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_port", {62'b0, o_c_rsp_vld, o_d_rsp_vld}, e.port ? 64'h1 : 64'h2);
          chk("rsp_data", 64'(o_c_rsp_vld ? o_c_rsp_rdata : o_d_rsp_rdata), 64'(e.data));
          chk("rsp_other_rdata", 64'(o_c_rsp_vld ? o_d_rsp_rdata : o_c_rsp_rdata), 64'h0);
        end
      end else begin
        chk("rsp_idle_rdata", 64'(o_c_rsp_rdata | o_d_rsp_rdata), 64'h0);
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_d_lock = 1'b0;
    i_c_req_vld = 0; i_c_req_addr = '0; i_c_req_wren = 0; i_c_req_wdata = '0; i_c_req_bmask = '0;
    i_d_req_vld = 0; i_d_req_addr = '0; i_d_req_wren = 0; i_d_req_wdata = '0; i_d_req_bmask = '0;

    // Reset state
    #12;
    chk("rst_stall", 64'(o_c_stall_cnt), 64'h0);
    chk("rst_rsp_vld", {62'b0, o_c_rsp_vld, o_d_rsp_vld}, 64'h0);
    chk("rst_rsp_rdata", 64'(o_c_rsp_rdata | o_d_rsp_rdata), 64'h0);
    chk("rst_mem_en", 64'(o_mem_en), 64'h0);
    next_cyc();
    i_reset = 1'b0;

    // Uncontended C read of 0x10
    i_c_req_vld = 1; i_c_req_addr = 32'h10;
    @(negedge i_clk);
    chk_gnt("c_rd", 1, 0, 32'h10, 0);
    push(1'b0, 32'hDEAD_BEEF);
    next_cyc();
    i_c_req_vld = 0;

    // D read of 0x30, leaves priority at C
    i_d_req_vld = 1; i_d_req_addr = 32'h30;
    @(negedge i_clk);
    chk_gnt("d_rd", 0, 1, 32'h30, 0);
    push(1'b1, 32'hCAFE_F00D);
    next_cyc();

    // Both valid four cycles: C, D, C, D
    i_c_req_vld = 1; i_c_req_addr = 32'h40;
    i_d_req_vld = 1; i_d_req_addr = 32'h44;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (k % 2 == 0) begin
        chk_gnt("rr_c", 1, 0, 32'h40, 0);
        push(1'b0, 32'hA500_0010);
      end else begin
        chk_gnt("rr_d", 0, 1, 32'h44, 0);
        push(1'b1, 32'hA500_0011);
      end
      next_cyc();
    end
    chk("rr_stall", 64'(o_c_stall_cnt), 64'd2);

    // Lock for three cycles: only D
    i_d_lock = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk_gnt("lock_d", 0, 1, 32'h44, 0);
      push(1'b1, 32'hA500_0011);
      next_cyc();
    end
    chk("lock_stall", 64'(o_c_stall_cnt), 64'd5);
    i_d_lock = 0; i_d_req_vld = 0;
    @(negedge i_clk);
    chk_gnt("unlock_c", 1, 0, 32'h40, 0);
    push(1'b0, 32'hA500_0010);
    next_cyc();
    i_c_req_vld = 0;
    chk("unlock_stall", 64'(o_c_stall_cnt), 64'd5);

    // D full write, then partial write, then C read-back of 0x20
    i_d_req_vld = 1; i_d_req_addr = 32'h20; i_d_req_wren = 1;
    i_d_req_wdata = 32'h1234_5678; i_d_req_bmask = 4'hF;
    @(negedge i_clk);
    chk_gnt("d_wr", 0, 1, 32'h20, 1);
    chk("d_wr_wdata", 64'(o_mem_wdata), 64'h1234_5678);
    chk("d_wr_bmask", 64'(o_mem_bmask), 64'hF);
    push(1'b1, '0);
    next_cyc();
    i_d_req_wdata = 32'hFFFF_FFFF; i_d_req_bmask = 4'h3;
    @(negedge i_clk);
    chk("d_wr2_bmask", 64'(o_mem_bmask), 64'h3);
    push(1'b1, '0);
    next_cyc();
    i_d_req_vld = 0; i_d_req_wren = 0; i_d_req_wdata = '0; i_d_req_bmask = '0;
    i_c_req_vld = 1; i_c_req_addr = 32'h20;
    @(negedge i_clk);
    chk_gnt("c_rdback", 1, 0, 32'h20, 0);
    push(1'b0, 32'h1234_FFFF);
    next_cyc();

    // Reset the cycle after a C read grant (prio is D at this point)
    i_c_req_addr = 32'h10;
    @(negedge i_clk);
    chk_gnt("c_rd_pre_rst", 1, 0, 32'h10, 0);
    next_cyc();
    i_c_req_vld = 0;
    i_reset = 1;
    #1;
    chk("rst_drop_c_vld", 64'(o_c_rsp_vld), 64'h0);
    chk("rst_drop_c_rdata", 64'(o_c_rsp_rdata), 64'h0);
    chk("rst_mid_stall", 64'(o_c_stall_cnt), 64'h0);
    next_cyc();
    i_reset = 0;
    i_c_req_vld = 1; i_c_req_addr = 32'h40;
    i_d_req_vld = 1; i_d_req_addr = 32'h44;
    @(negedge i_clk);
    chk_gnt("post_rst_prio", 1, 0, 32'h40, 0);
    push(1'b0, 32'hA500_0010);
    next_cyc();
    i_d_req_vld = 0;
    chk("post_rst_stall", 64'(o_c_stall_cnt), 64'h0);

    // Saturation: C locked out for 70000 cycles
    i_d_lock = 1;
    @(negedge i_clk);
    chk_gnt("sat_locked", 0, 0, '0, 0);
    repeat (65534) @(posedge i_clk);
    #1;
    chk("sat_fffe", 64'(o_c_stall_cnt), 64'hFFFE);
    next_cyc();
    chk("sat_ffff", 64'(o_c_stall_cnt), 64'hFFFF);
    repeat (4465) @(posedge i_clk);
    #1;
    chk("sat_no_wrap", 64'(o_c_stall_cnt), 64'hFFFF);
    i_c_req_vld = 0; i_d_lock = 0;

    repeat (2) next_cyc();
    chk("sb_empty", 64'(q.size()), 64'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
